// File: rtl/sqrt_iterative_hs.sv
// sqrt_iterative_hs: handshaked digit-recurrence square root for U1.(WL-1) operands.
// Optional round-to-nearest on the final edge when SQRT_ROUND_NEAREST_EN is defined.
module sqrt_iterative_hs #(
    parameter int WL  = 24,
    parameter int BPC = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          CE,
    input  logic [WL-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [WL-1:0] dout,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int ITER = WL / BPC;
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CMAX = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, nxt;
    logic [2*WL-1:0] rad, rad_t;
    logic [WL+1:0] rem;
    logic [WL+3:0] rem_t, trial;
    logic [WL-1:0] q, q_t, root_fin;
    logic [CW-1:0] cnt;
    logic load, step;

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else state <= nxt;
    end

    // next state and handshake flags; CE low holds the current state
    always_comb begin
        nxt = state == IDLE ? (CE && in_valid ? BUSY : IDLE) :
              state == BUSY ? (CE && cnt == '0 ? DONE : BUSY) :
                              (CE && out_ready ? IDLE : DONE);
        in_ready = state == IDLE;
        out_valid = state == DONE;
        load = CE && state == IDLE && in_valid;
        step = CE && state == BUSY;
    end

    // BPC radix-2 recurrence steps: bring down two radicand bits, try (2q+1)
    always_comb begin
        rem_t = {2'b00, rem};
        q_t = q;
        rad_t = rad;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            rem_t = {rem_t[WL+1:0], rad_t[2*WL-1 -: 2]};
            rad_t = rad_t << 2;
            trial = {2'b00, q_t, 2'b01};
            if (rem_t >= trial) begin
                rem_t = rem_t - trial;
                q_t = {q_t[WL-2:0], 1'b1};
            end else begin
                q_t = {q_t[WL-2:0], 1'b0};
            end
        end
`ifdef SQRT_ROUND_NEAREST_EN
        root_fin = rem_t > {4'b0000, q_t} ? (&q_t ? q_t : q_t + 1'b1) : q_t;
`else
        root_fin = q_t;
`endif
    end

    // datapath: capture operand, iterate, register the final root
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rad  <= '0;
            rem  <= '0;
            q    <= '0;
            cnt  <= '0;
            dout <= '0;
        end else if (load) begin
            rad <= {1'b0, din, {(WL-1){1'b0}}};
            rem <= '0;
            q   <= '0;
            cnt <= CMAX;
        end else if (step) begin
            rad <= rad_t;
            rem <= rem_t[WL+1:0];
            q   <= q_t;
            cnt <= cnt - 1'b1;
            if (cnt == '0) dout <= root_fin;
        end
    end
endmodule
